// File: rtl/wb_pkg.sv
// wb_pkg -- shared types, load-type codes and load extension for the writeback stage.
// Revision 1.0
`default_nettype none

package wb_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

    // Byte/half lane select by address offset, then sign or zero extension.
    function automatic logic [31:0] load_extend(input logic [31:0] raw,
                                                input logic [2:0]  funct3,
                                                input logic [1:0]  addr_lo);
        logic [7:0]  b;
        logic [15:0] h;
        case (addr_lo)
            2'd0:    b = raw[7:0];
            2'd1:    b = raw[15:8];
            2'd2:    b = raw[23:16];
            default: b = raw[31:24];
        endcase
        h = addr_lo[1] ? raw[31:16] : raw[15:0];
        case (funct3)
            LB:      load_extend = {{24{b[7]}}, b};
            LBU:     load_extend = {24'h0, b};
            LH:      load_extend = {{16{h[15]}}, h};
            LHU:     load_extend = {16'h0, h};
            default: load_extend = raw;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// wb_fifo -- synchronous FIFO of writeback entries with full/empty flags.
// Revision 1.0
`default_nettype none

module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      i_clk,
    input  logic      i_reset,
    input  logic      push,
    input  wb_entry_t wr_entry,
    input  logic      pop,
    output wb_entry_t rd_entry,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    wb_entry_t   mem [DEPTH];

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_entry = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= wr_entry;
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// wb_arbiter -- merges ALU and load results into one register-file write port with
// bounded load starvation. Define WB_FWD_EN to add the rs1/rs2 write bypass. Revision 1.0
`default_nettype none

module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_alu_valid,
    output logic        o_alu_ready,
    input  logic [4:0]  i_alu_rd,
    input  logic [31:0] i_alu_data,
    input  logic        i_mem_valid,
    output logic        o_mem_ready,
    input  logic [4:0]  i_mem_rd,
    input  logic [31:0] i_mem_raw,
    input  logic [2:0]  i_mem_funct3,
    input  logic [1:0]  i_mem_addr_lo,
    output logic        o_rd_wren,
    output logic [4:0]  o_rd_addr,
    output logic [31:0] o_rd_data,
    output logic        o_busy
`ifdef WB_FWD_EN
    ,
    input  logic [4:0]  i_fwd_rs1,
    input  logic [4:0]  i_fwd_rs2,
    output logic        o_fwd1_hit,
    output logic [31:0] o_fwd1_data,
    output logic        o_fwd2_hit,
    output logic [31:0] o_fwd2_data
`endif
);

    localparam int              SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);

    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;
    wb_entry_t     push_entry;
    wb_entry_t     pop_entry;
    logic [SW-1:0] starve_cnt;
    logic [SW-1:0] starve_nxt;
    logic          starve_take;
    logic          alu_take;
    logic          alu_write;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .push     (fifo_push),
        .wr_entry (push_entry),
        .pop      (fifo_pop),
        .rd_entry (pop_entry),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign o_mem_ready = !i_reset && !fifo_full;
    assign starve_take = !fifo_empty && (starve_cnt == STARVE_LIM);
    assign o_alu_ready = !i_reset && !starve_take;
    assign o_busy      = !fifo_empty || o_rd_wren;

    always_comb begin
        push_entry.rd   = i_mem_rd;
        push_entry.data = load_extend(i_mem_raw, i_mem_funct3, i_mem_addr_lo);
        // rd=0 loads complete the handshake but never occupy a slot.
        fifo_push       = i_mem_valid && o_mem_ready && (i_mem_rd != 5'd0);
        alu_take        = i_alu_valid && o_alu_ready;
        alu_write       = alu_take && (i_alu_rd != 5'd0);
        fifo_pop        = !fifo_empty && !alu_take;
        starve_nxt      = starve_cnt;
        if (fifo_empty || fifo_pop) begin
            starve_nxt = '0;
        end else if (alu_write && (starve_cnt != STARVE_LIM)) begin
            starve_nxt = starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            starve_cnt <= '0;
            o_rd_wren  <= 1'b0;
            o_rd_addr  <= 5'd0;
            o_rd_data  <= 32'd0;
        end else begin
            starve_cnt <= starve_nxt;
            if (alu_write) begin
                o_rd_wren <= 1'b1;
                o_rd_addr <= i_alu_rd;
                o_rd_data <= i_alu_data;
            end else if (fifo_pop) begin
                o_rd_wren <= 1'b1;
                o_rd_addr <= pop_entry.rd;
                o_rd_data <= pop_entry.data;
            end else begin
                o_rd_wren <= 1'b0;
            end
        end
    end

`ifdef WB_FWD_EN
    // Covers the register file's write delay for readers in the same cycle.
    assign o_fwd1_hit  = o_rd_wren && (o_rd_addr == i_fwd_rs1) && (i_fwd_rs1 != 5'd0);
    assign o_fwd2_hit  = o_rd_wren && (o_rd_addr == i_fwd_rs2) && (i_fwd_rs2 != 5'd0);
    assign o_fwd1_data = o_rd_data;
    assign o_fwd2_data = o_rd_data;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter -- self-checking bench for wb_arbiter: vector table, scoreboard, corner sequences.
// Revision 1.0
`default_nettype none

module tb_wb_arbiter;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_alu_valid;
    logic        o_alu_ready;
    logic [4:0]  i_alu_rd;
    logic [31:0] i_alu_data;
    logic        i_mem_valid;
    logic        o_mem_ready;
    logic [4:0]  i_mem_rd;
    logic [31:0] i_mem_raw;
    logic [2:0]  i_mem_funct3;
    logic [1:0]  i_mem_addr_lo;
    logic        o_rd_wren;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_data;
    logic        o_busy;
`ifdef WB_FWD_EN
    logic [4:0]  i_fwd_rs1;
    logic [4:0]  i_fwd_rs2;
    logic        o_fwd1_hit;
    logic [31:0] o_fwd1_data;
    logic        o_fwd2_hit;
    logic [31:0] o_fwd2_data;
`endif

    always #5 i_clk = ~i_clk;

    wb_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_alu_valid   (i_alu_valid),
        .o_alu_ready   (o_alu_ready),
        .i_alu_rd      (i_alu_rd),
        .i_alu_data    (i_alu_data),
        .i_mem_valid   (i_mem_valid),
        .o_mem_ready   (o_mem_ready),
        .i_mem_rd      (i_mem_rd),
        .i_mem_raw     (i_mem_raw),
        .i_mem_funct3  (i_mem_funct3),
        .i_mem_addr_lo (i_mem_addr_lo),
        .o_rd_wren     (o_rd_wren),
        .o_rd_addr     (o_rd_addr),
        .o_rd_data     (o_rd_data),
        .o_busy        (o_busy)
`ifdef WB_FWD_EN
        ,
        .i_fwd_rs1     (i_fwd_rs1),
        .i_fwd_rs2     (i_fwd_rs2),
        .o_fwd1_hit    (o_fwd1_hit),
        .o_fwd1_data   (o_fwd1_data),
        .o_fwd2_hit    (o_fwd2_hit),
        .o_fwd2_data   (o_fwd2_data)
`endif
    );

    typedef struct {
        logic [31:0] raw;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [4:0]  rd;
        logic [31:0] exp;
    } ld_vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    ld_vec_t vec [7];
    wr_t     mem_q [$];
    wr_t     pend_alu;
    bit      pend_alu_v;
    bit      alu_acc;
    bit      mem_acc;
    int      checks;
    int      errors;

    function automatic logic [31:0] ref_ext(logic [31:0] raw, logic [2:0] f3, logic [1:0] off);
        logic [31:0] sb;
        logic [31:0] sh;
        sb = raw >> (32'(off) * 8);
        sh = off[1] ? (raw >> 16) : raw;
        case (f3)
            3'b000:  return {{24{sb[7]}}, sb[7:0]};
            3'b100:  return {24'h0, sb[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b101:  return {16'h0, sh[15:0]};
            default: return raw;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Negedge sample: compare the write made at the last edge, then record what the next edge accepts.
    task automatic sample();
        wr_t w;
        @(negedge i_clk);
        if (pend_alu_v) begin
            check("alu_wren", 32'(o_rd_wren), 32'd1);
            check("alu_addr", 32'(o_rd_addr), 32'(pend_alu.rd));
            check("alu_data", o_rd_data, pend_alu.data);
        end else if (o_rd_wren) begin
            if (mem_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_write: got write to x%0d, expected no write", o_rd_addr);
            end else begin
                w = mem_q.pop_front();
                check("mem_addr", 32'(o_rd_addr), 32'(w.rd));
                check("mem_data", o_rd_data, w.data);
            end
        end
        alu_acc    = i_alu_valid && o_alu_ready;
        pend_alu_v = alu_acc && (i_alu_rd != 5'd0);
        pend_alu   = '{i_alu_rd, i_alu_data};
        mem_acc    = i_mem_valid && o_mem_ready;
        if (mem_acc && (i_mem_rd != 5'd0)) begin
            mem_q.push_back('{i_mem_rd, ref_ext(i_mem_raw, i_mem_funct3, i_mem_addr_lo)});
        end
    endtask

    task automatic advance();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive_mem(input logic v, input logic [4:0] rd, input logic [31:0] raw,
                             input logic [2:0] f3, input logic [1:0] off);
        i_mem_valid   = v;
        i_mem_rd      = rd;
        i_mem_raw     = raw;
        i_mem_funct3  = f3;
        i_mem_addr_lo = off;
    endtask

    initial begin
        int  pushes;
        int  wins;
        bit  started;
        bit  starved;
        bit  full_checked;
        bit  after_starve;
        bit  done;

        checks = 0;
        errors = 0;
        pend_alu_v = 0;
        i_reset = 1'b1;
        i_alu_valid = 1'b0;
        i_alu_rd = 5'd0;
        i_alu_data = 32'd0;
        drive_mem(1'b0, 5'd0, 32'd0, 3'b010, 2'd0);
`ifdef WB_FWD_EN
        i_fwd_rs1 = 5'd0;
        i_fwd_rs2 = 5'd0;
`endif

        vec[0] = '{32'h80FF7F01, 3'b000, 2'd3, 5'd1, 32'hFFFFFF80};
        vec[1] = '{32'h80FF7F01, 3'b100, 2'd1, 5'd2, 32'h0000007F};
        vec[2] = '{32'h80FF7F01, 3'b001, 2'd2, 5'd3, 32'hFFFF80FF};
        vec[3] = '{32'h80FF7F01, 3'b101, 2'd0, 5'd4, 32'h00007F01};
        vec[4] = '{32'h80FF7F01, 3'b010, 2'd0, 5'd5, 32'h80FF7F01};
        vec[5] = '{32'h80FF7F01, 3'b011, 2'd2, 5'd6, 32'h80FF7F01};
        vec[6] = '{32'h80FF7F01, 3'b000, 2'd0, 5'd7, 32'h00000001};

        // Reset state.
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_wren", 32'(o_rd_wren), 32'd0);
        check("rst_addr", 32'(o_rd_addr), 32'd0);
        check("rst_data", o_rd_data, 32'd0);
        check("rst_mem_ready", 32'(o_mem_ready), 32'd0);
        check("rst_alu_ready", 32'(o_alu_ready), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        i_reset = 1'b0;
        sample();
        check("idle_mem_ready", 32'(o_mem_ready), 32'd1);
        advance();

        // ALU only, then rd=0 consumed without a write.
        i_alu_valid = 1'b1; i_alu_rd = 5'd5; i_alu_data = 32'h1234;
        sample();
        check("alu_ready_idle", 32'(o_alu_ready), 32'd1);
        advance();
        i_alu_rd = 5'd0; i_alu_data = 32'hDEAD;
        sample();
        advance();
        i_alu_valid = 1'b0;
        sample();
        check("alu_rd0_nowrite", 32'(o_rd_wren), 32'd0);
        check("hold_addr", 32'(o_rd_addr), 32'd5);
        check("hold_data", o_rd_data, 32'h1234);
        advance();

`ifdef WB_FWD_EN
        i_alu_valid = 1'b1; i_alu_rd = 5'd7; i_alu_data = 32'hCAFE0007;
        i_fwd_rs1 = 5'd7; i_fwd_rs2 = 5'd0;
        sample();
        advance();
        i_alu_valid = 1'b0;
        sample();
        check("fwd1_hit", 32'(o_fwd1_hit), 32'd1);
        check("fwd1_data", o_fwd1_data, 32'hCAFE0007);
        check("fwd2_hit", 32'(o_fwd2_hit), 32'd0);
        advance();
`endif

        // Load extension table, each load on an idle arbiter.
        for (int i = 0; i < 7; i++) begin
            drive_mem(1'b1, vec[i].rd, vec[i].raw, vec[i].f3, vec[i].off);
            sample();
            check("ld_ready", 32'(o_mem_ready), 32'd1);
            advance();
            drive_mem(1'b0, 5'd0, 32'd0, 3'b010, 2'd0);
            sample();
            check("ld_lat_early", 32'(o_rd_wren), 32'd0);
            advance();
            sample();
            check("ld_wren", 32'(o_rd_wren), 32'd1);
            check("ld_data", o_rd_data, vec[i].exp);
            advance();
        end

        // Load to x0: handshake completes, nothing written.
        drive_mem(1'b1, 5'd0, 32'h5555AAAA, 3'b010, 2'd0);
        sample();
        advance();
        drive_mem(1'b0, 5'd0, 32'd0, 3'b010, 2'd0);
        repeat (3) begin
            sample();
            advance();
        end
        check("ld_rd0_busy", 32'(o_busy), 32'd0);

        // ALU and load in the same cycle: ALU first, load one cycle later.
        i_alu_valid = 1'b1; i_alu_rd = 5'd3; i_alu_data = 32'hA0A0A0A0;
        drive_mem(1'b1, 5'd4, 32'h0B0B0B0B, 3'b010, 2'd0);
        sample();
        advance();
        i_alu_valid = 1'b0;
        drive_mem(1'b0, 5'd0, 32'd0, 3'b010, 2'd0);
        sample();
        check("sim_first_addr", 32'(o_rd_addr), 32'd3);
        advance();
        sample();
        check("sim_second_wren", 32'(o_rd_wren), 32'd1);
        check("sim_second_addr", 32'(o_rd_addr), 32'd4);
        advance();
        sample();
        advance();

        // Full FIFO under continuous ALU traffic: bounded starvation.
        pushes = 0; wins = 0; started = 0; starved = 0;
        full_checked = 0; after_starve = 0; done = 0;
        i_alu_valid = 1'b1; i_alu_rd = 5'd1; i_alu_data = $urandom;
        drive_mem(1'b1, 5'd10, $urandom, 3'b010, 2'd0);
        for (int c = 0; c < 40 && !done; c++) begin
            sample();
            if (pushes == 4 && !full_checked) begin
                check("fifo_full_ready", 32'(o_mem_ready), 32'd0);
                full_checked = 1;
            end
            if (after_starve) begin
                check("ready_rise_after_pop", 32'(o_mem_ready), 32'd1);
                done = 1;
            end
            if (started && !starved && !o_alu_ready) begin
                check("starve_alu_wins", 32'(wins), 32'd8);
                check("starve_pop_ready_low", 32'(o_mem_ready), 32'd0);
                starved = 1;
                after_starve = 1;
            end
            if (started && !starved && alu_acc) wins++;
            if (mem_acc) begin
                pushes++;
                started = 1;
            end
            advance();
            if (alu_acc) begin
                i_alu_rd   = (i_alu_rd % 5'd31) + 5'd1;
                i_alu_data = $urandom;
            end
            drive_mem(pushes < 4, 5'(10 + pushes), $urandom, 3'b010, 2'd0);
        end
        if (!starved) begin
            checks++;
            errors++;
            $display("FAIL starve_timeout: got no starvation pop in 40 cycles, expected one");
        end
        i_alu_valid = 1'b0;
        drive_mem(1'b0, 5'd0, 32'd0, 3'b010, 2'd0);
        repeat (12) begin
            sample();
            advance();
        end
        check("drain_queue_empty", 32'(mem_q.size()), 32'd0);
        check("drain_busy", 32'(o_busy), 32'd0);

        // Reset with three loads buffered behind ALU traffic.
        i_alu_valid = 1'b1; i_alu_rd = 5'd9; i_alu_data = 32'h99;
        for (int k = 0; k < 3; k++) begin
            drive_mem(1'b1, 5'(20 + k), 32'h100 + 32'(k), 3'b010, 2'd0);
            sample();
            advance();
        end
        i_reset = 1'b1;
        #1;
        check("mid_rst_wren", 32'(o_rd_wren), 32'd0);
        check("mid_rst_busy", 32'(o_busy), 32'd0);
        check("mid_rst_mem_ready", 32'(o_mem_ready), 32'd0);
        check("mid_rst_alu_ready", 32'(o_alu_ready), 32'd0);
        mem_q.delete();
        pend_alu_v = 0;
        i_alu_valid = 1'b0;
        drive_mem(1'b0, 5'd0, 32'd0, 3'b010, 2'd0);
        advance();
        i_reset = 1'b0;
        advance();
        sample();
        check("post_rst_wren", 32'(o_rd_wren), 32'd0);
        check("post_rst_busy", 32'(o_busy), 32'd0);
        check("post_rst_mem_ready", 32'(o_mem_ready), 32'd1);
        advance();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback merge stage directly upstream of the register file.
- Combines two result sources into the register file's single write port:
  - single-cycle ALU results;
  - long-latency memory/load results delivered via valid/ready.
- Load data is byte/half aligned and sign/zero extended before buffering in a small FIFO.
- Bounded-starvation arbitration keeps loads from being blocked indefinitely by back-to-back ALU writes.

Parameters:
- DEPTH, 4, memory-result FIFO entries (power of two, >=2).
- STARVE_MAX, 8, consecutive cycles a non-empty FIFO may lose arbitration before it takes priority.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-high reset
- i_alu_valid  in  1  ALU result present
- o_alu_ready  out  1  ALU result consumed this cycle when valid&ready
- i_alu_rd  in  5  ALU destination register
- i_alu_data  in  32  ALU result
- i_mem_valid  in  1  load result present
- o_mem_ready  out  1  FIFO can accept
- i_mem_rd  in  5  load destination register
- i_mem_raw  in  32  raw aligned memory word
- i_mem_funct3  in  3  load type
- i_mem_addr_lo  in  2  byte offset of load address
- o_rd_wren  out  1  register file write enable
- o_rd_addr  out  5  register file write address
- o_rd_data  out  32  register file write data
- o_busy  out  1  FIFO non-empty or o_rd_wren high

Behaviour:
- Reset (async, i_reset high):
  - o_rd_wren=0, o_rd_addr=0, o_rd_data=0.
  - FIFO empty, starvation counter=0.
  - o_mem_ready=0 and o_alu_ready=0 while i_reset is high.
- o_mem_ready = !full (combinational, no same-cycle pop bypass). Push on i_mem_valid&o_mem_ready.
- Load extension is applied at push; the FIFO stores {rd, extended data}:
  - funct3 000 LB: sign-extend byte[addr_lo]
  - 100 LBU: zero-extend byte[addr_lo]
  - 001 LH: sign-extend half[addr_lo[1]]
  - 101 LHU: zero-extend half[addr_lo[1]]
  - 010 LW and all other codes: raw word
- rd=0 handling:
  - Memory entry with rd=0: accepted (handshake completes) but not pushed.
  - ALU entry with rd=0: consumed, produces no write, does not count as ALU win.
- Arbitration, each cycle; the result is registered into o_rd_* at the next posedge:
  - If starve_cnt==STARVE_MAX and FIFO non-empty: pop FIFO, o_alu_ready=0. Upstream holds the ALU result.
  - Else if i_alu_valid: o_alu_ready=1, write ALU result.
  - Else if FIFO non-empty: pop FIFO.
  - Else o_rd_wren=0 next cycle.
- starve_cnt:
  - Increments when FIFO non-empty and ALU wins.
  - Clears on any FIFO pop or when FIFO is empty.
  - Saturates at STARVE_MAX.
- Latency:
  - ALU: 1 cycle (valid at edge N -> o_rd_wren at N+1).
  - Memory: 2 cycles minimum (push at N, pop at N+1 -> write visible N+2).
- Full FIFO with simultaneous pop: ready stays low that cycle and rises the next.
- o_rd_wren is a single-cycle pulse per write; o_rd_addr/o_rd_data hold their last values when wren=0.
- Reset mid-operation discards all FIFO contents and any pending output write.

Optional Feature:
- Macro: WB_FWD_EN.
- When defined, adds ports:
  - i_fwd_rs1 (in, 5), i_fwd_rs2 (in, 5)
  - o_fwd1_hit (out, 1), o_fwd1_data (out, 32)
  - o_fwd2_hit (out, 1), o_fwd2_data (out, 32)
- hitN = o_rd_wren && o_rd_addr==i_fwd_rsN && i_fwd_rsN!=0; dataN=o_rd_data. Combinational bypass covering the register file's write delay.
- When undefined: ports and logic are absent.

Decomposition:
- Package wb_pkg:
  - funct3 localparams LB/LH/LW/LBU/LHU.
  - typedef wb_entry_t {logic[4:0] rd; logic[31:0] data;}.
  - function load_extend(raw, funct3, addr_lo).
- One sub-module: wb_fifo (synchronous FIFO of wb_entry_t, DEPTH entries, async reset, full/empty flags, push/pop).

Test Plan:
- Reset: assert i_reset mid-burst with 3 FIFO entries -> o_rd_wren=0, o_busy=0, o_mem_ready=1 one cycle after release.
- ALU only: rd=5, data=0x1234 -> o_rd_wren=1, addr=5, data=0x1234 next cycle; rd=0 -> no write.
- Load extension: raw=0x80FF7F01:
  - LB off3 -> 0xFFFFFF80
  - LBU off1 -> 0x0000007F
  - LH off2 -> 0xFFFF80FF
  - LHU off0 -> 0x00007F01
  - LW -> 0x80FF7F01
- Full FIFO: ALU valid every cycle, 4 loads pushed -> o_mem_ready=0 after 4th; first load written after exactly STARVE_MAX=8 ALU wins with o_alu_ready=0 that cycle.
- Simultaneous: ALU rd=3 and load rd=4 arrive same cycle with empty FIFO -> rd3 written at N+1, rd4 at N+2.
- WB_FWD_EN: o_rd_addr=7 write pending, i_fwd_rs1=7, i_fwd_rs2=0 -> fwd1_hit=1 with data match, fwd2_hit=0.
